instruction_store: RTL and testbench

Parametrised, writable instruction memory for the 9-bit core: it replaces fixed per-program ROMs with `NUM_PROGS` loadable program banks. Each bank has a registered one-cycle fetch port, a per-bank program length and out-of-range HALT substitution. A sticky halt state blocks further fetches once a HALT word is delivered. The block sits between the fetch stage (PC → instruction) and the test/boot loader, which writes programs and selects the active bank.

---
 rtl/instruction_store_pkg.sv | 19 +
 rtl/instruction_store_ram.sv | 35 +++
 rtl/instruction_store.sv | 102 ++++++++++
 tb/tb_instruction_store.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_store_pkg.sv
// Shared defaults, halt encoding and FSM state codes for the instruction store.
package instruction_store_pkg;

  localparam int unsigned INSTR_W_DEF   = 9;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned NUM_PROGS_DEF = 2;
  localparam int unsigned CNT_W_DEF     = 16;

  localparam logic [8:0] HALT_WORD_DEF = 9'b0111_00_010;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Bank select width; a single bank still gets a 1-bit select.
  function automatic int unsigned bank_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instruction_store_ram.sv
// Word array with one write port and a registered read port; the read can be
// overridden with a substitute word (used for out-of-range fetches).
module instr_bank_ram #(
  parameter int unsigned     WIDTH    = 9,
  parameter int unsigned     IDX_W    = 9,
  parameter int unsigned     WORDS    = 512,
  parameter logic [WIDTH-1:0] SUB_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  input  logic             rsub,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] rnext_c
);

  logic [WIDTH-1:0] mem [WORDS];

  // Word that the next read will register; lets the owner see it a cycle early.
  assign rnext_c = rsub ? SUB_WORD : mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rnext_c;
  end

endmodule

// File: rtl/instruction_store.sv
// Loadable multi-bank instruction memory with 1-cycle fetch, per-bank length,
// HALT substitution, sticky halt and a saturating fetch counter.
module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int unsigned         INSTR_W   = INSTR_W_DEF,
  parameter int unsigned         ADDR_W    = ADDR_W_DEF,
  parameter int unsigned         NUM_PROGS = NUM_PROGS_DEF,
  parameter logic [INSTR_W-1:0]  HALT_WORD = INSTR_W'(HALT_WORD_DEF),
  parameter int unsigned         CNT_W     = CNT_W_DEF,
  parameter int unsigned         BANK_W    = bank_width(NUM_PROGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  input  logic               sel_req,
  input  logic [BANK_W-1:0]  sel_bank,
  output logic [BANK_W-1:0]  active_bank,
  output logic               halted,
  input  logic               load_en,
  input  logic [BANK_W-1:0]  load_bank,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IDX_W = BANK_W + ADDR_W;
  localparam int unsigned WORDS = NUM_PROGS * DEPTH;
  localparam int unsigned LEN_W = ADDR_W + 1;

  logic [0:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q [NUM_PROGS];
  logic               accept_c, oob_c, halt_hit_c, load_ok_c;
  logic [INSTR_W-1:0] next_word_c;
  logic [BANK_W-1:0]  sel_clamped_c;

  assign accept_c      = fetch_req && (state_q == ST_RUN);
  assign oob_c         = {1'b0, fetch_addr} >= len_q[active_bank];
  assign halt_hit_c    = accept_c && (next_word_c == HALT_WORD);
  assign load_ok_c     = load_en && (32'(load_bank) < NUM_PROGS);
  assign sel_clamped_c = (32'(sel_bank) >= NUM_PROGS) ? BANK_W'(NUM_PROGS - 1) : sel_bank;

  instr_bank_ram #(
    .WIDTH    (INSTR_W),
    .IDX_W    (IDX_W),
    .WORDS    (WORDS),
    .SUB_WORD (HALT_WORD)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (load_ok_c),
    .waddr   ({load_bank, load_addr}),
    .wdata   (load_data),
    .re      (accept_c),
    .raddr   ({active_bank, fetch_addr}),
    .rsub    (oob_c),
    .rdata   (instruction),
    .rnext_c (next_word_c)
  );

  // Halt is decided at the fetch edge so it appears alongside the HALT word.
  always_comb begin
    state_d = state_q;
    if (sel_req)         state_d = ST_RUN;
    else if (halt_hit_c) state_d = ST_HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      halted      <= 1'b0;
      instr_valid <= 1'b0;
      active_bank <= '0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      halted      <= (state_d == ST_HALTED);
      instr_valid <= accept_c;
      if (sel_req) begin
        active_bank <= sel_clamped_c;
        fetch_count <= accept_c ? CNT_W'(1) : '0;
      end else if (accept_c && (fetch_count != '1)) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  // Fetches in the same cycle still compare against the pre-update length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_PROGS; b++) len_q[b] <= LEN_W'(DEPTH);
    end else if (load_ok_c && load_last) begin
      len_q[load_bank] <= {1'b0, load_addr} + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store with a fetch scoreboard.
module tb_instruction_store;

  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned NUM_PROGS = 2;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BANK_W    = 1;
  localparam logic [INSTR_W-1:0] HALT = 9'h0E2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fetch_req = 1'b0;
  logic [ADDR_W-1:0]  fetch_addr = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               sel_req = 1'b0;
  logic [BANK_W-1:0]  sel_bank = '0;
  logic [BANK_W-1:0]  active_bank;
  logic               halted;
  logic               load_en = 1'b0;
  logic [BANK_W-1:0]  load_bank = '0;
  logic [ADDR_W-1:0]  load_addr = '0;
  logic [INSTR_W-1:0] load_data = '0;
  logic               load_last = 1'b0;
  logic [CNT_W-1:0]   fetch_count;

  int vectors = 0;
  int miscompares = 0;
  logic [INSTR_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  instruction_store #(
    .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_PROGS(NUM_PROGS),
    .HALT_WORD(HALT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr_valid(instr_valid), .instruction(instruction),
    .sel_req(sel_req), .sel_bank(sel_bank), .active_bank(active_bank),
    .halted(halted),
    .load_en(load_en), .load_bank(load_bank), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; any word due this cycle must be presented now.
  task automatic tick();
    logic exp_v;
    logic [INSTR_W-1:0] e;
    @(posedge clk); #1;
    exp_v = (exp_q.size() != 0);
    chk("instr_valid", 32'(instr_valid), 32'(exp_v));
    if (exp_v) begin
      e = exp_q.pop_front();
      chk("instruction", 32'(instruction), 32'(e));
    end
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] e);
    fetch_req = 1'b1; fetch_addr = a; exp_q.push_back(e);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic fetch_dropped(input logic [ADDR_W-1:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic load(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                      input logic [INSTR_W-1:0] d, input logic last);
    load_en = 1'b1; load_bank = b; load_addr = a; load_data = d; load_last = last;
    tick();
    load_en = 1'b0; load_last = 1'b0;
  endtask

  task automatic select(input logic [BANK_W-1:0] b);
    sel_req = 1'b1; sel_bank = b;
    tick();
    sel_req = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instruction", 32'(instruction), 0);
    chk("rst_active_bank", 32'(active_bank), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(fetch_count), 0);
    @(negedge clk); rst_n = 1'b1;

    load(0, 0, 9'h0B2, 0);
    load(0, 1, 9'h0CB, 0);
    load(0, 2, 9'h0B6, 0);
    load(0, 3, 9'h0E1, 1);
    load(0, 200, 9'h123, 0);
    load(0, 255, 9'h07F, 0);
    load(1, 0, 9'h155, 0);
    load(1, 1, 9'h0AA, 0);
    load(1, 2, 9'h030, 0);
    load(1, 3, HALT, 0);

    // Back-to-back program read
    fetch(0, 9'h0B2);
    chk("count_first", 32'(fetch_count), 1);
    fetch(1, 9'h0CB);
    fetch(2, 9'h0B6);
    fetch(3, 9'h0E1);
    chk("count_four", 32'(fetch_count), 4);
    chk("not_halted", 32'(halted), 0);

    // Past program length substitutes HALT and sticks
    fetch(5, HALT);
    chk("halt_oob", 32'(halted), 1);
    chk("count_halt", 32'(fetch_count), 5);
    fetch_dropped(0);
    chk("halt_blocks_count", 32'(fetch_count), 5);

    select(1);
    chk("sel_bank", 32'(active_bank), 1);
    chk("sel_unhalt", 32'(halted), 0);
    chk("sel_count", 32'(fetch_count), 0);
    fetch(0, 9'h155);
    chk("count_bank1", 32'(fetch_count), 1);

    // Read-before-write on the same address
    load_en = 1'b1; load_bank = 1; load_addr = 2; load_data = 9'h1FF;
    fetch_req = 1'b1; fetch_addr = 2; exp_q.push_back(9'h030);
    tick();
    fetch_req = 1'b0; load_en = 1'b0;
    fetch(2, 9'h1FF);

    // Fetch and select together: old bank delivers, count restarts at 1
    fetch_req = 1'b1; fetch_addr = 1; exp_q.push_back(9'h0AA);
    sel_req = 1'b1; sel_bank = 0;
    tick();
    fetch_req = 1'b0; sel_req = 1'b0;
    chk("sel_fetch_bank", 32'(active_bank), 0);
    chk("sel_fetch_count", 32'(fetch_count), 1);

    // load_last alongside a fetch uses the old length
    load_en = 1'b1; load_bank = 0; load_addr = 1; load_data = 9'h011; load_last = 1'b1;
    fetch_req = 1'b1; fetch_addr = 3; exp_q.push_back(9'h0E1);
    tick();
    fetch_req = 1'b0; load_en = 1'b0; load_last = 1'b0;
    fetch(1, 9'h011);
    fetch(2, HALT);
    chk("halt_len_boundary", 32'(halted), 1);
    chk("count_len", 32'(fetch_count), 4);

    // Stored HALT word halts; select with same-edge halt ends in RUN
    select(1);
    chk("reselect_unhalt", 32'(halted), 0);
    fetch(3, HALT);
    chk("halt_stored", 32'(halted), 1);
    select(1);
    fetch_req = 1'b1; fetch_addr = 3; exp_q.push_back(HALT);
    sel_req = 1'b1; sel_bank = 1;
    tick();
    fetch_req = 1'b0; sel_req = 1'b0;
    chk("sel_beats_halt", 32'(halted), 0);
    chk("sel_beats_halt_count", 32'(fetch_count), 1);
    fetch(0, 9'h155);

    // Reset while a fetch is in flight
    fetch_req = 1'b1; fetch_addr = 0;
    @(posedge clk); #2; rst_n = 1'b0; #1;
    fetch_req = 1'b0;
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_instruction", 32'(instruction), 0);
    chk("midrst_bank", 32'(active_bank), 0);
    chk("midrst_halted", 32'(halted), 0);
    chk("midrst_count", 32'(fetch_count), 0);
    @(negedge clk); rst_n = 1'b1;
    fetch(200, 9'h123);
    fetch(255, 9'h07F);
    chk("len_reset_count", 32'(fetch_count), 2);
    chk("len_reset_halted", 32'(halted), 0);

    // Counter saturation
    force dut.fetch_count = 16'hFFFE;
    #1;
    release dut.fetch_count;
    chk("count_forced", 32'(fetch_count), 32'h0000_FFFE);
    fetch(0, 9'h0B2);
    chk("count_sat1", 32'(fetch_count), 32'h0000_FFFF);
    fetch(0, 9'h0B2);
    chk("count_sat2", 32'(fetch_count), 32'h0000_FFFF);
    fetch(0, 9'h0B2);
    chk("count_sat3", 32'(fetch_count), 32'h0000_FFFF);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
